rr_channel_mux: RTL and testbench

- Parametrised, registered N-channel, W-bit selector with valid/ready handshakes on every input and on the output.
- Offers three selection modes: fixed priority, round robin, and manual select.
- Sits between multiple result/operand sources (ALU, memory read, immediate, I/O) and a single downstream consumer in the CPU datapath.
- Successor to the plain 2:1/4:1 combinational selectors; adds arbitration, backpressure and one output register stage.

---
 rtl/rr_channel_mux_pkg.sv | 14 +
 rtl/rr_channel_mux_grant.sv | 71 +++++++
 rtl/rr_channel_mux.sv | 73 +++++++
 tb/tb_rr_channel_mux.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/rr_channel_mux_pkg.sv
// Shared mode encodings and small helpers for the round-robin channel mux.
package rr_channel_mux_pkg;

  localparam logic [1:0] MUX_MODE_FIXED  = 2'b00;
  localparam logic [1:0] MUX_MODE_RR     = 2'b01;
  localparam logic [1:0] MUX_MODE_MANUAL = 2'b10;
  localparam logic [1:0] MUX_MODE_RSVD   = 2'b11;

  // Channel index following k, wrapping at n.
  function automatic int unsigned next_chan(input int unsigned k, input int unsigned n);
    return (k + 32'd1 >= n) ? 32'd0 : k + 32'd1;
  endfunction

endpackage

// File: rtl/rr_channel_mux_grant.sv
// Combinational grant selection: one-hot grant plus encoded index for the chosen channel.
module rr_grant_logic
  import rr_channel_mux_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic [CHANNELS-1:0] in_valid,
  input  logic [1:0]          mode,
  input  logic [SEL_W-1:0]    sel,
  input  logic [SEL_W-1:0]    rr_ptr,
  output logic [CHANNELS-1:0] grant,
  output logic [SEL_W-1:0]    grant_idx
);

  logic             found_s;
  logic [SEL_W-1:0] scan_idx_s;

  // Pick the granted channel according to the active mode.
  always_comb begin
    grant      = {CHANNELS{1'b0}};
    grant_idx  = {SEL_W{1'b0}};
    found_s    = 1'b0;
    scan_idx_s = {SEL_W{1'b0}};
    case (mode)
      MUX_MODE_FIXED: begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (!found_s && in_valid[i]) begin
            found_s   = 1'b1;
            grant_idx = SEL_W'(i);
          end else begin
            found_s = found_s;
          end
        end
      end
      MUX_MODE_RR: begin
        // Scan starts at rr_ptr; rr_ptr is always < CHANNELS so the sum wraps once.
        for (int off = 0; off < CHANNELS; off++) begin
          scan_idx_s = SEL_W'((int'(rr_ptr) + off) % CHANNELS);
          if (!found_s && in_valid[scan_idx_s]) begin
            found_s   = 1'b1;
            grant_idx = scan_idx_s;
          end else begin
            found_s = found_s;
          end
        end
      end
      MUX_MODE_MANUAL: begin
        if (int'(sel) < CHANNELS) begin
          if (in_valid[sel]) begin
            found_s   = 1'b1;
            grant_idx = sel;
          end else begin
            found_s = 1'b0;
          end
        end else begin
          found_s = 1'b0;
        end
      end
      default: begin
        found_s = 1'b0;
      end
    endcase
    if (found_s) begin
      grant[grant_idx] = 1'b1;
    end else begin
      grant = {CHANNELS{1'b0}};
    end
  end

endmodule

// File: rtl/rr_channel_mux.sv
// Registered N-channel selector with fixed-priority, round-robin and manual modes
// and valid/ready handshakes on every input and on the output.
module rr_channel_mux
  import rr_channel_mux_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [1:0]                mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [CHANNELS-1:0] grant_s;
  logic [SEL_W-1:0]    grant_idx_s;
  logic [SEL_W-1:0]    rr_ptr_r;
  logic                load_en_s;
  logic                xfer_s;
  logic [WIDTH-1:0]    sel_data_s;

  rr_grant_logic #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_grant (
    .in_valid  (in_valid),
    .mode      (mode),
    .sel       (sel),
    .rr_ptr    (rr_ptr_r),
    .grant     (grant_s),
    .grant_idx (grant_idx_s)
  );

  assign load_en_s  = !out_valid || out_ready;
  assign xfer_s     = load_en_s && (|grant_s);
  assign in_ready   = (rst || !load_en_s) ? {CHANNELS{1'b0}} : grant_s;
  assign sel_data_s = in_data[int'(grant_idx_s)*WIDTH +: WIDTH];

  // Output register: load on transfer, empty when the slot frees with nothing granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= {WIDTH{1'b0}};
      out_chan  <= {SEL_W{1'b0}};
    end else if (load_en_s) begin
      if (xfer_s) begin
        out_valid <= 1'b1;
        out_data  <= sel_data_s;
        out_chan  <= grant_idx_s;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  // Round-robin pointer advances past the winner only on round-robin transfers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r <= {SEL_W{1'b0}};
    end else if (xfer_s && (mode == MUX_MODE_RR)) begin
      rr_ptr_r <= SEL_W'(next_chan(32'(grant_idx_s), 32'(CHANNELS)));
    end
  end

endmodule

// File: tb/tb_rr_channel_mux.sv
// Directed self-checking bench for rr_channel_mux (4-channel and 3-channel instances).
module tb_rr_channel_mux;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [1:0]  mode;
  logic [1:0]  sel;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic        out_ready;

  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [1:0]  mode3;
  logic [1:0]  sel3;
  logic [7:0]  out_data3;
  logic [1:0]  out_chan3;
  logic        out_valid3;
  logic        out_ready3;

  int checks = 0;
  int errors = 0;

  rr_channel_mux #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel), .out_data(out_data), .out_chan(out_chan),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  rr_channel_mux #(.WIDTH(8), .CHANNELS(3)) dut3 (
    .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .mode(mode3), .sel(sel3), .out_data(out_data3), .out_chan(out_chan3),
    .out_valid(out_valid3), .out_ready(out_ready3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 4'hF; in_valid3 = 3'b111; mode = 2'b00; mode3 = 2'b00;
    out_ready = 1'b1; out_ready3 = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", out_data); end
    checks++; if (out_chan !== 2'd0) begin errors++; $display("FAIL reset_chan: got %0d expected 0", out_chan); end
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready); end
    checks++; if (in_ready3 !== 3'b000) begin errors++; $display("FAIL reset_in_ready3: got %b expected 000", in_ready3); end
    checks++; if (dut.rr_ptr_r !== 2'd0) begin errors++; $display("FAIL reset_rr_ptr: got %0d expected 0", dut.rr_ptr_r); end
    in_valid = 4'b0000; in_valid3 = 3'b000;
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_hold();
    in_data = {8'h00, 8'hA5, 8'h00, 8'h00};
    mode = 2'b10; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b0;
    #1;
    checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL hold_grant: got %b expected 0100", in_ready); end
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_chan !== 2'd2) begin
      errors++; $display("FAIL hold_load: got v=%b d=%h c=%0d expected v=1 d=a5 c=2", out_valid, out_data, out_chan); end
    in_valid = 4'b0101;
    step();
    checks++; if (out_data !== 8'hA5 || in_ready !== 4'b0000) begin
      errors++; $display("FAIL hold_stable: got d=%h rdy=%b expected d=a5 rdy=0000", out_data, in_ready); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 4'b0000) begin
      errors++; $display("FAIL async_reset: got v=%b d=%h rdy=%b expected v=0 d=00 rdy=0000", out_valid, out_data, in_ready); end
    step();
    rst = 1'b0; in_valid = 4'b0000;
    step();
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got %b expected 0", out_valid); end
  endtask

  task automatic test_fixed_priority();
    in_data = {8'h33, 8'h22, 8'h11, 8'h00};
    mode = 2'b00; in_valid = 4'b1110; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL fixed_in_ready[%0d]: got %b expected 0010", i, in_ready); end
      step();
      checks++; if (out_valid !== 1'b1 || out_chan !== 2'd1 || out_data !== 8'h11) begin
        errors++; $display("FAIL fixed_out[%0d]: got v=%b c=%0d d=%h expected v=1 c=1 d=11", i, out_valid, out_chan, out_data); end
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_chan;
    in_data = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
    mode = 2'b01; in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_chan = 2'(i % 4);
      #1;
      checks++; if (in_ready !== (4'b0001 << exp_chan)) begin
        errors++; $display("FAIL rr_in_ready[%0d]: got %b expected one-hot %0d", i, in_ready, exp_chan); end
      step();
      checks++; if (out_chan !== exp_chan || out_data !== {6'b110000, exp_chan}) begin
        errors++; $display("FAIL rr_out[%0d]: got c=%0d d=%h expected c=%0d d=%h", i, out_chan, out_data, exp_chan, {6'b110000, exp_chan}); end
    end
    checks++; if (dut.rr_ptr_r !== 2'd2) begin errors++; $display("FAIL rr_ptr_wrap: got %0d expected 2", dut.rr_ptr_r); end
  endtask

  task automatic test_backpressure();
    in_valid = 4'b0000; out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", out_valid); end
    in_data = {24'h000000, 8'h5A}; in_valid = 4'b0001; out_ready = 1'b0;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL bp_first_grant: got %b expected 0001", in_ready); end
    step();
    in_data = {24'h000000, 8'h6B};
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_stall_ready[%0d]: got %b expected 0000", i, in_ready); end
      checks++; if (out_valid !== 1'b1 || out_data !== 8'h5A || out_chan !== 2'd0) begin
        errors++; $display("FAIL bp_stall_out[%0d]: got v=%b d=%h c=%0d expected v=1 d=5a c=0", i, out_valid, out_data, out_chan); end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL bp_release_ready: got %b expected 0001", in_ready); end
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h6B) begin
      errors++; $display("FAIL bp_drain_and_load: got v=%b d=%h expected v=1 d=6b", out_valid, out_data); end
    in_valid = 4'b0000;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_manual();
    in_data = {8'h77, 8'h03, 8'h02, 8'h01};
    mode = 2'b10; sel = 2'd3; in_valid = 4'b0111; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL manual_no_grant: got %b expected 0000", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL manual_idle: got %b expected 0", out_valid); end
    in_valid = 4'b1111;
    #1;
    checks++; if (in_ready !== 4'b1000) begin errors++; $display("FAIL manual_grant: got %b expected 1000", in_ready); end
    step();
    checks++; if (out_valid !== 1'b1 || out_chan !== 2'd3 || out_data !== 8'h77) begin
      errors++; $display("FAIL manual_out: got v=%b c=%0d d=%h expected v=1 c=3 d=77", out_valid, out_chan, out_data); end
    out_ready = 1'b0; sel = 2'd0;
    step();
    checks++; if (out_chan !== 2'd3 || out_data !== 8'h77) begin
      errors++; $display("FAIL manual_sel_change_hold: got c=%0d d=%h expected c=3 d=77", out_chan, out_data); end
    out_ready = 1'b1; in_valid = 4'b0000;
    step();
  endtask

  task automatic test_nonpow2_reserved();
    logic [1:0] exp_chan;
    in_data3 = {8'h92, 8'h91, 8'h90};
    mode3 = 2'b01; in_valid3 = 3'b111; out_ready3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_chan = 2'(i % 3);
      step();
      checks++; if (out_valid3 !== 1'b1 || out_chan3 !== exp_chan || out_data3 !== {6'b100100, exp_chan}) begin
        errors++; $display("FAIL np2_rr[%0d]: got v=%b c=%0d d=%h expected v=1 c=%0d", i, out_valid3, out_chan3, out_data3, exp_chan); end
    end
    mode3 = 2'b11;
    #1;
    checks++; if (in_ready3 !== 3'b000) begin errors++; $display("FAIL rsvd_in_ready: got %b expected 000", in_ready3); end
    step();
    checks++; if (out_valid3 !== 1'b0) begin errors++; $display("FAIL rsvd_drain: got %b expected 0", out_valid3); end
    mode3 = 2'b10; sel3 = 2'd3;
    #1;
    checks++; if (in_ready3 !== 3'b000) begin errors++; $display("FAIL np2_sel_oob_ready: got %b expected 000", in_ready3); end
    step();
    checks++; if (out_valid3 !== 1'b0) begin errors++; $display("FAIL np2_sel_oob_valid: got %b expected 0", out_valid3); end
  endtask

  initial begin
    rst = 1'b1; in_data = 32'h0; in_valid = 4'h0; mode = 2'b00; sel = 2'd0; out_ready = 1'b0;
    in_data3 = 24'h0; in_valid3 = 3'b000; mode3 = 2'b00; sel3 = 2'd0; out_ready3 = 1'b0;
    test_reset();
    test_reset_mid_hold();
    test_fixed_priority();
    test_round_robin();
    test_backpressure();
    test_manual();
    test_nonpow2_reserved();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
